// File: rtl/output_subsystem_pkg.sv
// ---------------------------------------------------------------------------
// output_subsystem_pkg
// Purpose : shared constants and types for the matrix-to-UART print engine.
//   - ASCII codes used when formatting matrix elements
//   - FSM state encoding and separator phase encoding
//   - default MAX_DIM, RAM bus widths, converter helpers
//   - uart_tx port convention: tx_start (1-cycle request), tx_data[7:0]
//     (stable while tx_start is high), tx_busy (frame in flight),
//     tx_done (1-cycle pulse after the stop bit)
// ---------------------------------------------------------------------------
package output_subsystem_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int MAX_DIM_DEFAULT = 5;
  localparam int ADDR_W          = 9;
  localparam int DATA_W          = 32;

  // Elements are saturated to 16 bits, so five decimal digits always suffice.
  localparam int          NUM_DIGITS = 5;
  localparam logic [2:0]  LAST_POW   = 3'd4;
  localparam logic [15:0] VALUE_SAT  = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_CONV,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  // Which kind of byte is being transmitted for the current element.
  typedef enum logic [1:0] {
    PH_DIGITS,  // decimal digits of the element
    PH_SEP,     // space, or CR on the last column
    PH_LF       // LF closing a row
  } phase_t;

  // Decimal weight for converter step idx (0 -> 10000 ... 4 -> 1).
  function automatic logic [15:0] pow10(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'd10000;
      3'd1:    return 16'd1000;
      3'd2:    return 16'd100;
      3'd3:    return 16'd10;
      default: return 16'd1;
    endcase
  endfunction

endpackage

// File: rtl/output_subsystem_if.sv
// ---------------------------------------------------------------------------
// output_subsystem_if
// Purpose : matrix RAM read port used by the print engine.
//   w_rd_en   : read strobe (engine -> RAM)
//   w_rd_addr : read address (engine -> RAM)
//   w_rd_data : read data, valid exactly one cycle after w_rd_en (RAM -> engine)
// Modports : master = engine side, slave = RAM side.
// ---------------------------------------------------------------------------
interface output_subsystem_if;
  import output_subsystem_pkg::*;

  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;

  modport master (output w_rd_en, output w_rd_addr, input w_rd_data);
  modport slave  (input w_rd_en, input w_rd_addr, output w_rd_data);

endinterface

// File: rtl/output_subsystem_uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// Purpose : 8N1 serial transmitter, LSB first, line idles high.
// Ports   :
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_tx_start   : 1-cycle request, accepted only while not busy
//   i_tx_data    : byte to send, sampled with i_tx_start
//   o_tx         : serial line
//   o_tx_busy    : frame in flight
//   o_tx_done    : 1-cycle pulse once the stop bit has completed
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_data,
  output logic       o_tx,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             r_busy;
  logic             r_done;
  logic [9:0]       r_shift;   // {stop, data[7:0], start}; bit 0 is on the line
  logic [CNT_W-1:0] r_clk_cnt;
  logic [3:0]       r_bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_shift   <= '1;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_tx_start) begin
          r_busy    <= 1'b1;
          r_shift   <= {1'b1, i_tx_data, 1'b0};
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
        end
      end else if (r_clk_cnt == CNT_LAST) begin
        r_clk_cnt <= '0;
        if (r_bit_cnt == 4'd9) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_shift   <= {1'b1, r_shift[9:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else begin
        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
      end
    end
  end

  // Reset clears r_busy, so the line returns high without waiting for a clock.
  assign o_tx      = r_busy ? r_shift[0] : 1'b1;
  assign o_tx_busy = r_busy;
  assign o_tx_done = r_done;

endmodule

// File: rtl/output_subsystem.sv
// ---------------------------------------------------------------------------
// output_subsystem
// Purpose : reads an M x N matrix from RAM (row-major) and prints it as ASCII
//           decimal over UART: elements separated by a space, rows end CR LF.
// Ports   :
//   clk, rst_n     : clock, asynchronous active-low reset
//   w_en_output    : enable; low aborts back to idle
//   w_start        : 1-cycle start request
//   w_base_addr    : RAM address of element (0,0)
//   w_dim_m/n      : rows / columns, sampled on an accepted start
//   ram            : RAM read port (master side)
//   uart_tx        : serial line
//   w_tx_busy      : high from accepted start to done/abort
//   w_tx_done      : 1-cycle pulse after the final LF
//   w_error_flag   : last accepted start had illegal dimensions
// ---------------------------------------------------------------------------
module output_subsystem
  import output_subsystem_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int MAX_DIM   = MAX_DIM_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      w_en_output,
  input  logic                      w_start,
  input  logic [ADDR_W-1:0]         w_base_addr,
  input  logic [31:0]               w_dim_m,
  input  logic [31:0]               w_dim_n,
  output_subsystem_if.master        ram,
  output logic                      uart_tx,
  output logic                      w_tx_busy,
  output logic                      w_tx_done,
  output logic                      w_error_flag
);

  localparam int DIM_W = $clog2(MAX_DIM + 1);

  state_t             r_state;
  state_t             w_state_next;
  phase_t             r_phase;
  logic [DIM_W-1:0]   r_dim_m;
  logic [DIM_W-1:0]   r_dim_n;
  logic [DIM_W-1:0]   r_row;
  logic [DIM_W-1:0]   r_col;
  logic [ADDR_W-1:0]  r_addr;
  logic [15:0]        r_value;
  logic [3:0]         r_digit;
  logic [2:0]         r_pow_idx;
  logic [3:0]         r_digits [NUM_DIGITS];
  logic [2:0]         r_ndigits;
  logic [2:0]         r_byte_idx;
  logic               r_error;

  logic               w_start_ok;
  logic               w_dims_ok;
  logic               w_last_col;
  logic               w_last_row;
  logic [15:0]        w_pow;
  logic               w_conv_ge;
  logic [7:0]         w_byte;
  logic               w_rd_en;
  logic               w_tx_start;
  logic [7:0]         w_tx_data;
  logic               w_uart_line;
  logic               w_uart_busy;
  logic               w_uart_done;

  assign w_start_ok = (r_state == S_IDLE) && w_en_output && w_start;
  assign w_dims_ok  = (w_dim_m != 32'd0) && (w_dim_m <= 32'(MAX_DIM)) &&
                      (w_dim_n != 32'd0) && (w_dim_n <= 32'(MAX_DIM));
  assign w_last_col = (r_col == r_dim_n - DIM_W'(1));
  assign w_last_row = (r_row == r_dim_m - DIM_W'(1));
  assign w_pow      = pow10(r_pow_idx);
  assign w_conv_ge  = (r_value >= w_pow);

  always_comb begin
    w_byte = ASCII_LF;
    case (r_phase)
      PH_DIGITS: w_byte = ASCII_ZERO + {4'd0, r_digits[r_byte_idx]};
      PH_SEP:    w_byte = w_last_col ? ASCII_CR : ASCII_SPACE;
      default:   w_byte = ASCII_LF;
    endcase
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // ---------------- next state / strobes ----------------
  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_tx_start   = 1'b0;
    w_tx_data    = w_byte;
    case (r_state)
      S_IDLE:  if (w_start_ok && w_dims_ok) w_state_next = S_READ;
      S_READ: begin
        w_rd_en      = w_en_output;
        w_state_next = S_LATCH;
      end
      S_LATCH: w_state_next = S_CONV;
      S_CONV:  if (!w_conv_ge && (r_pow_idx == LAST_POW)) w_state_next = S_SEND;
      S_SEND: begin
        // Waiting on !busy also covers a byte left in flight by an abort.
        if (!w_uart_busy && w_en_output) begin
          w_tx_start   = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_uart_done) begin
          case (r_phase)
            PH_DIGITS: w_state_next = S_SEND;
            PH_SEP:    w_state_next = w_last_col ? S_SEND : S_READ;
            default:   w_state_next = w_last_row ? S_DONE : S_READ;
          endcase
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (!w_en_output) w_state_next = S_IDLE;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= PH_DIGITS;
      r_dim_m    <= '0;
      r_dim_n    <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_addr     <= '0;
      r_value    <= '0;
      r_digit    <= '0;
      r_pow_idx  <= '0;
      r_ndigits  <= '0;
      r_byte_idx <= '0;
      r_error    <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) r_digits[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_error <= !w_dims_ok;
            if (w_dims_ok) begin
              r_addr  <= w_base_addr;
              r_dim_m <= DIM_W'(w_dim_m);
              r_dim_n <= DIM_W'(w_dim_n);
              r_row   <= '0;
              r_col   <= '0;
            end
          end
        end
        S_LATCH: begin
          r_value    <= (|ram.w_rd_data[31:16]) ? VALUE_SAT : ram.w_rd_data[15:0];
          r_digit    <= '0;
          r_pow_idx  <= '0;
          r_ndigits  <= '0;
          r_byte_idx <= '0;
          r_phase    <= PH_DIGITS;
        end
        S_CONV: begin
          if (w_conv_ge) begin
            r_value <= r_value - w_pow;
            r_digit <= r_digit + 4'd1;
          end else begin
            // Leading zeros are dropped; the units digit is always kept so 0 prints "0".
            if ((r_digit != 4'd0) || (r_ndigits != 3'd0) || (r_pow_idx == LAST_POW)) begin
              r_digits[r_ndigits] <= r_digit;
              r_ndigits           <= r_ndigits + 3'd1;
            end
            r_digit <= '0;
            if (r_pow_idx != LAST_POW) r_pow_idx <= r_pow_idx + 3'd1;
          end
        end
        S_WAIT: begin
          if (w_uart_done) begin
            case (r_phase)
              PH_DIGITS: begin
                if (r_byte_idx == r_ndigits - 3'd1) r_phase <= PH_SEP;
                else                                 r_byte_idx <= r_byte_idx + 3'd1;
              end
              PH_SEP: begin
                if (w_last_col) begin
                  r_phase <= PH_LF;
                end else begin
                  r_col  <= r_col + DIM_W'(1);
                  r_addr <= r_addr + ADDR_W'(1);
                end
              end
              default: begin
                // Row-major storage makes the next row start at the next address.
                r_col  <= '0;
                r_row  <= r_row + DIM_W'(1);
                r_addr <= r_addr + ADDR_W'(1);
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  uart_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_uart_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_tx_start (w_tx_start),
    .i_tx_data  (w_tx_data),
    .o_tx       (w_uart_line),
    .o_tx_busy  (w_uart_busy),
    .o_tx_done  (w_uart_done)
  );

  assign ram.w_rd_en   = w_rd_en;
  assign ram.w_rd_addr = r_addr;
  assign uart_tx       = w_uart_line;
  assign w_tx_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_tx_done     = (r_state == S_DONE);
  assign w_error_flag  = r_error;

endmodule
